ysyx_22040125_load_unit: RTL and testbench

//  Memory-read side of the execute stage: takes the effective address produced by the ALU adder plus
//  the load funct3, issues one 64-bit aligned read on the data-memory read channel, then lane-selects
//  and sign/zero-extends the returned doubleword. Result goes to writeback. One load in flight.

---
 rtl/ysyx_22040125_load_unit_pkg.sv | 42 ++++
 rtl/ysyx_22040125_load_align.sv | 47 ++++
 rtl/ysyx_22040125_load_unit.sv | 127 ++++++++++++
 tb/tb_ysyx_22040125_load_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040125_load_unit_pkg.sv
// ============================================================================
// Module : ysyx_22040125_load_unit_pkg
// Brief  : Load funct3 encodings, FSM state encoding and misalignment helper
//          shared by the load unit and its lane-select datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ysyx_22040125_load_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Access size comes from funct3[1:0]; any offset bit below the size is a misalignment.
  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] a);
    logic r;
    r = 1'b0;
    case (f3[1:0])
      2'b01:   r = a[0];
      2'b10:   r = |a[1:0];
      2'b11:   r = |a;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22040125_load_align.sv
// ============================================================================
// Module : ysyx_22040125_load_align
// Brief  : Combinational lane select plus sign/zero extension of a doubleword.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_22040125_load_align
  import ysyx_22040125_load_unit_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [63:0] data_o
);

  logic [2:0]  off;
  logic [5:0]  sh_amt;
  logic [63:0] sh;

  // Offset bits below the access size are dropped so a lane never crosses byte 7.
  always_comb begin
    off = addr_i;
    case (funct3_i[1:0])
      2'b00:   off = addr_i;
      2'b01:   off = {addr_i[2:1], 1'b0};
      2'b10:   off = {addr_i[2], 2'b00};
      default: off = 3'b000;
    endcase
  end

  assign sh_amt = {off, 3'b000};
  assign sh     = rdata_i >> sh_amt;

  always_comb begin
    data_o = sh;
    case (funct3_i[1:0])
      2'b00:   data_o = funct3_i[2] ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'b01:   data_o = funct3_i[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'b10:   data_o = funct3_i[2] ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: data_o = sh;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_22040125_load_unit.sv
// ============================================================================
// Module : ysyx_22040125_load_unit
// Brief  : Single-outstanding load unit: aligned doubleword read, lane select,
//          extension, writeback handshake. Macro YSYX_22040125_MISALIGN_TRAP_EN
//          traps misaligned accesses instead of forcing alignment.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_22040125_load_unit
  import ysyx_22040125_load_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [RD_W-1:0]   req_rd_i,
  output logic              mem_arvalid_o,
  input  logic              mem_arready_i,
  output logic [ADDR_W-1:0] mem_araddr_o,
  input  logic              mem_rvalid_i,
  output logic              mem_rready_o,
  input  logic [63:0]       mem_rdata_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [63:0]       wb_data_o,
  output logic [RD_W-1:0]   wb_rd_o,
  output logic              wb_err_o
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [2:0]          f3_q,    f3_d;
  logic [RD_W-1:0]     rd_q,    rd_d;
  logic [63:0]         data_q,  data_d;
  logic                err_q,   err_d;
  logic [63:0]         align_data;
  logic                bad_req;

`ifdef YSYX_22040125_MISALIGN_TRAP_EN
  assign bad_req = (req_funct3_i == F3_BAD) || misaligned(req_funct3_i, req_addr_i[2:0]);
`else
  assign bad_req = (req_funct3_i == F3_BAD);
`endif

  ysyx_22040125_load_align u_align (
    .rdata_i  (mem_rdata_i),
    .addr_i   (addr_q[2:0]),
    .funct3_i (f3_q),
    .data_o   (align_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          addr_d = req_addr_i;
          f3_d   = req_funct3_i;
          rd_d   = req_rd_i;
          if (bad_req) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            data_d  = '0;
          end else begin
            state_d = S_REQ;
            err_d   = 1'b0;
          end
        end
      end
      S_REQ: begin
        if (mem_arready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          data_d  = align_data;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (wb_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decode straight from state so reset clears them without a clock.
  assign req_ready_o   = (state_q == S_IDLE);
  assign mem_arvalid_o = (state_q == S_REQ);
  assign mem_rready_o  = (state_q == S_WAIT);
  assign wb_valid_o    = (state_q == S_RESP);
  assign mem_araddr_o  = {addr_q[ADDR_W-1:3], 3'b000};
  assign wb_data_o     = data_q;
  assign wb_rd_o       = rd_q;
  assign wb_err_o      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040125_load_unit.sv
// ============================================================================
// Module : tb_ysyx_22040125_load_unit
// Brief  : Directed loads with a queue scoreboard and an independent monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22040125_load_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic [2:0]  req_funct3_i = '0;
  logic [4:0]  req_rd_i = '0;
  logic        mem_arvalid_o;
  logic        mem_arready_i = 1'b0;
  logic [31:0] mem_araddr_o;
  logic        mem_rvalid_i = 1'b0;
  logic        mem_rready_o;
  logic [63:0] mem_rdata_i = '0;
  logic        wb_valid_o;
  logic        wb_ready_i = 1'b0;
  logic [63:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        wb_err_o;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        err;
    logic [31:0] araddr;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   wb_cnt  = 0;

  localparam logic [63:0] RD_A = 64'h1122334455667788;
  localparam logic [63:0] RD_B = 64'h0123456789ABCDEF;

  ysyx_22040125_load_unit #(.ADDR_W(32), .RD_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_funct3_i  (req_funct3_i),
    .req_rd_i      (req_rd_i),
    .mem_arvalid_o (mem_arvalid_o),
    .mem_arready_i (mem_arready_i),
    .mem_araddr_o  (mem_araddr_o),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rready_o  (mem_rready_o),
    .mem_rdata_i   (mem_rdata_i),
    .wb_valid_o    (wb_valid_o),
    .wb_ready_i    (wb_ready_i),
    .wb_data_o     (wb_data_o),
    .wb_rd_o       (wb_rd_o),
    .wb_err_o      (wb_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: checks presented address and writeback fields against the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_arvalid_o) begin
        if (sb.size() == 0) chk("araddr_unexpected", 64'(mem_araddr_o), 64'hFFFF_FFFF);
        else chk("araddr", 64'(mem_araddr_o), 64'(sb[0].araddr));
      end
      if (wb_valid_o) begin
        if (sb.size() == 0) begin
          chk("wb_unexpected", 64'(wb_valid_o), 64'd0);
        end else begin
          chk("wb_data", wb_data_o, sb[0].data);
          chk("wb_rd", 64'(wb_rd_o), 64'(sb[0].rd));
          chk("wb_err", 64'(wb_err_o), 64'(sb[0].err));
          if (wb_ready_i) begin
            void'(sb.pop_front());
            wb_cnt++;
          end
        end
      end
    end
  end

  task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [63:0] rdat, input int ar_st, input int wb_st,
                         input logic [63:0] ed, input logic ee, input logic mem);
    exp_t e;
    int   n;
    int   t0;
    int   wb_before;
    e.data = ed; e.rd = rd; e.err = ee; e.araddr = {a[31:3], 3'b000};
    sb.push_back(e);
    wb_before     = wb_cnt;
    mem_arready_i = (ar_st == 0);
    wb_ready_i    = (wb_st == 0);
    req_valid_i   = 1'b1;
    req_addr_i    = a;
    req_funct3_i  = f3;
    req_rd_i      = rd;
    t0            = cyc;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    if (mem) begin
      n = 0;
      while (!mem_arvalid_o && n < 10) begin @(posedge clk); #1; n++; end
      chk("arvalid_seen", 64'(mem_arvalid_o), 64'd1);
      for (int k = 0; k < ar_st; k++) begin
        chk("stall_ar_req_ready", 64'(req_ready_o), 64'd0);
        @(posedge clk); #1;
        chk("stall_arvalid", 64'(mem_arvalid_o), 64'd1);
      end
      mem_arready_i = 1'b1;
      @(posedge clk); #1;
      chk("rready", 64'(mem_rready_o), 64'd1);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rdat;
      @(posedge clk); #1;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 64'hDEAD_BEEF_DEAD_BEEF;
    end else begin
      chk("no_arvalid", 64'(mem_arvalid_o), 64'd0);
    end
    n = 0;
    while (!wb_valid_o && n < 10) begin @(posedge clk); #1; n++; end
    chk("wb_valid_seen", 64'(wb_valid_o), 64'd1);
    if (ar_st == 0 && wb_st == 0)
      chk("latency", 64'(cyc - t0), mem ? 64'd3 : 64'd1);
    for (int k = 0; k < wb_st; k++) begin
      chk("stall_wb_req_ready", 64'(req_ready_o), 64'd0);
      @(posedge clk); #1;
    end
    wb_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("wb_drop", 64'(wb_valid_o), 64'd0);
    chk("wb_once", 64'(wb_cnt - wb_before), 64'd1);
    chk("idle_ready", 64'(req_ready_o), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);
    chk("rst_arvalid", 64'(mem_arvalid_o), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_wb_data", wb_data_o, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_load(32'h8000_0008, 3'b011, 5'd1,  RD_A, 0, 0, 64'h1122334455667788, 1'b0, 1'b1);
    do_load(32'h8000_0003, 3'b000, 5'd2,  RD_B, 0, 0, 64'hFFFFFFFFFFFFFF89, 1'b0, 1'b1);
    do_load(32'h8000_0003, 3'b100, 5'd3,  RD_B, 0, 0, 64'h0000000000000089, 1'b0, 1'b1);
    do_load(32'h8000_0006, 3'b001, 5'd4,  RD_B, 0, 0, 64'h0000000000000123, 1'b0, 1'b1);
    do_load(32'h8000_0000, 3'b010, 5'd5,  RD_B, 0, 0, 64'hFFFFFFFF89ABCDEF, 1'b0, 1'b1);
    do_load(32'h8000_0000, 3'b110, 5'd6,  RD_B, 0, 0, 64'h0000000089ABCDEF, 1'b0, 1'b1);
    do_load(32'h8000_0002, 3'b001, 5'd7,  RD_B, 0, 0, 64'hFFFFFFFFFFFF89AB, 1'b0, 1'b1);
    do_load(32'h8000_0002, 3'b101, 5'd8,  RD_B, 0, 0, 64'h00000000000089AB, 1'b0, 1'b1);
    do_load(32'h8000_0007, 3'b000, 5'd9,  RD_B, 0, 0, 64'h0000000000000001, 1'b0, 1'b1);
    do_load(32'h8000_0004, 3'b010, 5'd10, RD_B, 0, 0, 64'h0000000001234567, 1'b0, 1'b1);
    do_load(32'h8000_0010, 3'b011, 5'd11, RD_B, 5, 3, 64'h0123456789ABCDEF, 1'b0, 1'b1);
`ifdef YSYX_22040125_MISALIGN_TRAP_EN
    do_load(32'h8000_0002, 3'b010, 5'd12, RD_B, 0, 0, 64'd0, 1'b1, 1'b0);
    do_load(32'h8000_0005, 3'b101, 5'd13, RD_B, 0, 0, 64'd0, 1'b1, 1'b0);
`else
    do_load(32'h8000_0002, 3'b010, 5'd12, RD_B, 0, 0, 64'hFFFFFFFF89ABCDEF, 1'b0, 1'b1);
    do_load(32'h8000_0005, 3'b101, 5'd13, RD_B, 0, 0, 64'h0000000000004567, 1'b0, 1'b1);
`endif
    do_load(32'h8000_0000, 3'b111, 5'd14, RD_B, 0, 0, 64'd0, 1'b1, 1'b0);

    // Abandon a load in WAIT via reset.
    mem_arready_i = 1'b1;
    wb_ready_i    = 1'b1;
    req_valid_i   = 1'b1;
    req_addr_i    = 32'h8000_0018;
    req_funct3_i  = 3'b011;
    req_rd_i      = 5'd15;
    sb.push_back('{64'd0, 5'd15, 1'b0, 32'h8000_0018});
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_rready", 64'(mem_rready_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_rready", 64'(mem_rready_o), 64'd0);
    chk("arst_arvalid", 64'(mem_arvalid_o), 64'd0);
    chk("arst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("arst_wb_err", 64'(wb_err_o), 64'd0);
    chk("arst_wb_data", wb_data_o, 64'd0);
    chk("arst_wb_rd", 64'(wb_rd_o), 64'd0);
    chk("arst_araddr", 64'(mem_araddr_o), 64'd0);
    chk("arst_req_ready", 64'(req_ready_o), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = RD_A;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("late_rvalid_no_wb", 64'(wb_valid_o), 64'd0);
      chk("late_rvalid_ready", 64'(req_ready_o), 64'd1);
      @(posedge clk); #1;
    end

    do_load(32'h8000_0001, 3'b000, 5'd16, RD_A, 0, 0, 64'h0000000000000077, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
